// File: rtl/clk_frac_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Optional feature macro used by the design files: CLK_FRAC_GEN_SHADOW_EN.
package clk_frac_gen_pkg;

   // Default configuration: 24-bit accumulators and a 1024-clock lock debounce.
   localparam int ACC_W_DEF        = 24;
   localparam int LOCK_STRETCH_DEF = 1024;

   typedef logic [ACC_W_DEF-1:0] inc_t;

   // 25 MHz PLL clock -> 18.432 MHz-equivalent enable rate.
   localparam inc_t DEFAULT_INC_DEF = 24'd12369506;

   // Top-level sequencing states.
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STRETCH   = 2'd1,
      RUN       = 2'd2
   } state_t;

   // The debounce counter must be able to hold the value LOCK_STRETCH.
   function automatic int lock_cnt_w(input int stretch);
      return $clog2(stretch + 1);
   endfunction

   localparam int LOCK_CNT_W = lock_cnt_w(LOCK_STRETCH_DEF);

   // The channel-select port is at least one bit wide, even for a single channel.
   function automatic int sel_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/clk_frac_acc.sv
// One phase-accumulator channel: increment register, accumulator, and
// registered enable/square-wave outputs.
// With CLK_FRAC_GEN_SHADOW_EN defined, writes go to a shadow register and are
// transferred to the live increment on the next overflow (or at once while idle).
module clk_frac_acc #(
   parameter int              ACC_W       = 24,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             run_en,
   input  logic             wr_en,
   input  logic [ACC_W-1:0] wr_data,
   output logic             ce,
   output logic             clk
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   // Carry out of this sum is the overflow; it always uses the increment currently live.
   assign sum = {1'b0, acc} + {1'b0, inc};

   // Accumulate while running; otherwise hold everything at zero.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         ce  <= 1'b0;
         clk <= 1'b0;
      end else if (run_en) begin
         acc <= sum[ACC_W-1:0];
         ce  <= sum[ACC_W];
         clk <= sum[ACC_W-1];
      end else begin
         acc <= '0;
         ce  <= 1'b0;
         clk <= 1'b0;
      end
   end

`ifdef CLK_FRAC_GEN_SHADOW_EN
   logic [ACC_W-1:0] shadow;
   logic             pending;

   // Retune only on an overflow edge so the output never shows a short period;
   // a write on that same edge stays pending for the following overflow.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         inc     <= DEFAULT_INC;
         shadow  <= DEFAULT_INC;
         pending <= 1'b0;
      end else begin
         if (pending && (!run_en || sum[ACC_W])) begin
            inc     <= shadow;
            pending <= 1'b0;
         end
         if (wr_en) begin
            shadow  <= wr_data;
            pending <= 1'b1;
         end
      end
   end
`else
   // Immediate update: the sum on the following edge already uses the new value.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         inc <= DEFAULT_INC;
      end else if (wr_en) begin
         inc <= wr_data;
      end
   end
`endif

endmodule

// File: rtl/clk_frac_gen.sv
// N-channel fractional clock-enable generator. Debounces the PLL lock,
// releases the downstream reset, and runs one DDS accumulator per channel.
// Optional feature macro: CLK_FRAC_GEN_SHADOW_EN (glitch-free retune via shadow registers).
//
// inc_wr is a single-cycle write strobe with no back-pressure: every write is
// accepted on the edge it is presented, in every state; an inc_sel that names no
// channel is dropped silently.
module clk_frac_gen
   import clk_frac_gen_pkg::*;
#(
   parameter int               CHANNELS     = 2,
   parameter int               ACC_W        = ACC_W_DEF,
   parameter logic [ACC_W-1:0] DEFAULT_INC  = ACC_W'(DEFAULT_INC_DEF),
   parameter int               LOCK_STRETCH = LOCK_STRETCH_DEF,
   localparam int              SEL_W        = sel_w(CHANNELS)
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic                pll_locked,
   input  logic                inc_wr,
   input  logic [SEL_W-1:0]    inc_sel,
   input  logic [ACC_W-1:0]    inc_data,
   output logic [CHANNELS-1:0] ce_out,
   output logic [CHANNELS-1:0] clk_out,
   output logic                ready,
   output logic                rst_out_n,
   output state_t              dbg_state
);

   localparam int              CNT_W    = lock_cnt_w(LOCK_STRETCH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STRETCH - 1);

   logic             lock_meta;
   logic             lock_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             run_en;

   // Two-flop synchroniser for the asynchronous PLL lock indicator.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // Lock debounce FSM; ready and rst_out_n are registered alongside the state.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         ready     <= 1'b0;
         rst_out_n <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               cnt <= '0;
               if (lock_s) state <= STRETCH;
            end
            STRETCH: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  ready     <= 1'b1;
                  rst_out_n <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state     <= WAIT_LOCK;
                  ready     <= 1'b0;
                  rst_out_n <= 1'b0;
               end
            end
            default: begin
               state     <= WAIT_LOCK;
               cnt       <= '0;
               ready     <= 1'b0;
               rst_out_n <= 1'b0;
            end
         endcase
      end
   end

   // Qualifying with lock_s clears the accumulators on the very edge that leaves RUN.
   assign run_en    = (state == RUN) && lock_s;
   assign dbg_state = state;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clk_frac_acc #(
         .ACC_W       (ACC_W),
         .DEFAULT_INC (DEFAULT_INC)
      ) u_acc (
         .clock_in (clock_in),
         .reset_n  (reset_n),
         .run_en   (run_en),
         .wr_en    (inc_wr && (inc_sel == SEL_W'(i))),
         .wr_data  (inc_data),
         .ce       (ce_out[i]),
         .clk      (clk_out[i])
      );
   end

endmodule
